// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the in-order core: per-stage enables, valid tracking,
// load-use stall/bubble insertion, branch squash and saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int NUM_STAGES        = 5,
   parameter int REG_ADDR_W        = 5,
   parameter int CNT_W             = 32,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_STAGES      = 3
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  redirect,
   input  logic                  clear_counters,
   output logic                  pc_write_en,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] flush,
   output logic                  bubble_id_ex,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count,
   output logic [CNT_W-1:0]      retired_count
);

   // Elaboration-time guards on the parameter ranges this control scheme supports.
   if (NUM_STAGES < 3) begin : g_bad_num_stages
      $error("pipeline_hazard_ctrl: NUM_STAGES must be at least 3");
   end
   if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_stall_cycles
      $error("pipeline_hazard_ctrl: LOAD_STALL_CYCLES must be 1..7");
   end
   if (FLUSH_STAGES < 1 || FLUSH_STAGES > NUM_STAGES - 1) begin : g_bad_flush_stages
      $error("pipeline_hazard_ctrl: FLUSH_STAGES must be 1..NUM_STAGES-1");
   end

   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

   logic                  run_q;
   logic [NUM_STAGES-1:0] valid_q;
   logic [NUM_STAGES-1:0] valid_d;
   logic [2:0]            scnt_q;
   logic [2:0]            scnt_d;
   logic                  go;
   logic                  hz;
   logic                  redirect_v;
   logic                  stall;
   logic                  rs1_hit;
   logic                  rs2_hit;

   assign go         = run_q & enable;
   assign rs1_hit    = rs1_used_id & (rs1_id == rd_ex);
   assign rs2_hit    = rs2_used_id & (rs2_id == rd_ex);
   assign hz         = valid_q[1] & valid_q[2] & mem_read_ex & (rd_ex != '0) & (rs1_hit | rs2_hit);
   // A redirect from an empty resolve stage is stale and must not squash anything.
   assign redirect_v = go & redirect & valid_q[FLUSH_STAGES];
   assign stall      = go & ~redirect_v & (hz | (scnt_q != '0));

   always_comb begin
      pc_write_en = 1'b0;
      stage_en    = '0;
      flush       = '0;
      valid_d     = valid_q;
      scnt_d      = scnt_q;
      if (go) begin
         pc_write_en = 1'b1;
         stage_en    = '1;
         valid_d     = {valid_q[NUM_STAGES-2:0], 1'b1};
         if (redirect_v) begin
            // Squash every stage younger than the resolving one; IF refetches at the target.
            for (int i = 1; i <= FLUSH_STAGES; i++) begin
               flush[i] = 1'b1;
            end
            valid_d = valid_d & ~flush;
            scnt_d  = '0;
         end else if (stall) begin
            // IF and ID hold their instructions while a bubble enters EX.
            pc_write_en  = 1'b0;
            stage_en[0]  = 1'b0;
            stage_en[1]  = 1'b0;
            flush[2]     = 1'b1;
            valid_d[0]   = valid_q[0];
            valid_d[1]   = valid_q[1];
            valid_d[2]   = 1'b0;
            scnt_d       = (scnt_q == '0) ? STALL_RELOAD : scnt_q - 3'd1;
         end
      end
   end

   assign bubble_id_ex = flush[2];
   assign stage_valid  = valid_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         run_q   <= 1'b0;
         valid_q <= '0;
         scnt_q  <= '0;
      end else begin
         run_q   <= 1'b1;
         valid_q <= valid_d;
         scnt_q  <= scnt_d;
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != '1)) ? v + 1'b1 : v;
   endfunction

   // A clear request wins over any increment in the same cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_count   <= '0;
         flush_count   <= '0;
         retired_count <= '0;
      end else if (clear_counters) begin
         stall_count   <= '0;
         flush_count   <= '0;
         retired_count <= '0;
      end else begin
         stall_count   <= sat_inc(stall_count, stall);
         flush_count   <= sat_inc(flush_count, redirect_v);
         retired_count <= sat_inc(retired_count, go & valid_q[NUM_STAGES-1]);
      end
   end

   a_stall_holds_pc : assert property (@(posedge clk) disable iff (!arst_n)
      stall |-> (!pc_write_en && !stage_en[0] && !stage_en[1]));
   a_frozen_quiet : assert property (@(posedge clk) disable iff (!arst_n)
      !go |-> (stage_en == '0 && flush == '0 && !pc_write_en));
   a_bubble_matches_flush : assert property (@(posedge clk) disable iff (!arst_n)
      bubble_id_ex == flush[2]);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table of stimulus patterns with expected
// control/state/counter values, plus corner sequences on a 4-bit, 3-bubble instance.
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       arst_n;
   logic       enable;
   logic [4:0] rs1_id;
   logic [4:0] rs2_id;
   logic       rs1_used_id;
   logic       rs2_used_id;
   logic [4:0] rd_ex;
   logic       mem_read_ex;
   logic       redirect;
   logic       clear_counters;

   logic        pc_a, bub_a;
   logic [4:0]  sen_a, fl_a, val_a;
   logic [31:0] st_a, fc_a, rt_a;
   logic        pc_b, bub_b;
   logic [4:0]  sen_b, fl_b, val_b;
   logic [3:0]  st_b, fc_b, rt_b;

   pipeline_hazard_ctrl dut_a (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect(redirect), .clear_counters(clear_counters),
      .pc_write_en(pc_a), .stage_en(sen_a), .flush(fl_a), .bubble_id_ex(bub_a), .stage_valid(val_a),
      .stall_count(st_a), .flush_count(fc_a), .retired_count(rt_a)
   );

   pipeline_hazard_ctrl #(.CNT_W(4), .LOAD_STALL_CYCLES(3)) dut_b (
      .clk(clk), .arst_n(arst_n), .enable(enable),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
      .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect(redirect), .clear_counters(clear_counters),
      .pc_write_en(pc_b), .stage_en(sen_b), .flush(fl_b), .bubble_id_ex(bub_b), .stage_valid(val_b),
      .stall_count(st_b), .flush_count(fc_b), .retired_count(rt_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef enum int {P_IDLE, P_HZ1, P_RD0, P_NOUSE, P_NOMR, P_HZ2, P_REDIR_HZ, P_REDIR, P_FRZ, P_CLR} pat_t;
   typedef enum int {E_OFF, E_RUN, E_STALL, E_REDIR} ek_t;

   typedef struct {
      pat_t        pat;
      ek_t         ek;
      logic [4:0]  val;
      logic [31:0] st;
      logic [31:0] fc;
      logic [31:0] rt;
   } vec_t;

   localparam int EW = 12 + 5 + 96;
   logic [EW-1:0] exp_q[$];
   vec_t          vecs[26];
   int            n_checks = 0;
   int            n_pass   = 0;

   // {pc_write_en, stage_en, flush, bubble_id_ex}
   localparam logic [11:0] CTL_OFF   = 12'b0_00000_00000_0;
   localparam logic [11:0] CTL_RUN   = 12'b1_11111_00000_0;
   localparam logic [11:0] CTL_STALL = 12'b0_11100_00100_1;
   localparam logic [11:0] CTL_REDIR = 12'b1_11111_01110_1;

   function automatic logic [11:0] exp_ctl(input ek_t e);
      case (e)
         E_RUN:   return CTL_RUN;
         E_STALL: return CTL_STALL;
         E_REDIR: return CTL_REDIR;
         default: return CTL_OFF;
      endcase
   endfunction

   function automatic vec_t mk(input pat_t p, input ek_t e, input logic [4:0] v,
                               input int st, input int fc, input int rt);
      vec_t r;
      r.pat = p; r.ek = e; r.val = v;
      r.st = 32'(st); r.fc = 32'(fc); r.rt = 32'(rt);
      return r;
   endfunction

   // driver
   task automatic drive_pat(input pat_t p);
      enable = 1'b1; rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
      rd_ex = 5'd0; mem_read_ex = 1'b0; redirect = 1'b0; clear_counters = 1'b0;
      case (p)
         P_HZ1:      begin rs1_id = 5'd5; rs1_used_id = 1'b1; rd_ex = 5'd5; mem_read_ex = 1'b1; end
         P_RD0:      begin rs1_id = 5'd0; rs1_used_id = 1'b1; rd_ex = 5'd0; mem_read_ex = 1'b1; end
         P_NOUSE:    begin rs1_id = 5'd5; rs2_id = 5'd5; rd_ex = 5'd5; mem_read_ex = 1'b1; end
         P_NOMR:     begin rs1_id = 5'd5; rs1_used_id = 1'b1; rd_ex = 5'd5; end
         P_HZ2:      begin rs1_id = 5'd7; rs1_used_id = 1'b1; rs2_id = 5'd5; rs2_used_id = 1'b1;
                           rd_ex = 5'd5; mem_read_ex = 1'b1; end
         P_REDIR_HZ: begin rs1_id = 5'd5; rs1_used_id = 1'b1; rd_ex = 5'd5; mem_read_ex = 1'b1;
                           redirect = 1'b1; end
         P_REDIR:    redirect = 1'b1;
         P_FRZ:      begin rs1_id = 5'd5; rs1_used_id = 1'b1; rd_ex = 5'd5; mem_read_ex = 1'b1;
                           enable = 1'b0; end
         P_CLR:      clear_counters = 1'b1;
         default:    ;
      endcase
   endtask

   // scoreboard compare
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   initial begin
      logic [EW-1:0] e;

      drive_pat(P_IDLE);
      arst_n = 1'b0;

      vecs[0]  = mk(P_IDLE,     E_OFF,   5'b00000, 0, 0, 0);
      vecs[1]  = mk(P_IDLE,     E_RUN,   5'b00000, 0, 0, 0);
      vecs[2]  = mk(P_IDLE,     E_RUN,   5'b00001, 0, 0, 0);
      vecs[3]  = mk(P_IDLE,     E_RUN,   5'b00011, 0, 0, 0);
      vecs[4]  = mk(P_IDLE,     E_RUN,   5'b00111, 0, 0, 0);
      vecs[5]  = mk(P_IDLE,     E_RUN,   5'b01111, 0, 0, 0);
      vecs[6]  = mk(P_IDLE,     E_RUN,   5'b11111, 0, 0, 0);
      vecs[7]  = mk(P_HZ1,      E_STALL, 5'b11111, 0, 0, 1);
      vecs[8]  = mk(P_IDLE,     E_RUN,   5'b11011, 1, 0, 2);
      vecs[9]  = mk(P_RD0,      E_RUN,   5'b10111, 1, 0, 3);
      vecs[10] = mk(P_NOUSE,    E_RUN,   5'b01111, 1, 0, 4);
      vecs[11] = mk(P_NOMR,     E_RUN,   5'b11111, 1, 0, 4);
      vecs[12] = mk(P_HZ2,      E_STALL, 5'b11111, 1, 0, 5);
      vecs[13] = mk(P_IDLE,     E_RUN,   5'b11011, 2, 0, 6);
      vecs[14] = mk(P_IDLE,     E_RUN,   5'b10111, 2, 0, 7);
      vecs[15] = mk(P_IDLE,     E_RUN,   5'b01111, 2, 0, 8);
      vecs[16] = mk(P_REDIR_HZ, E_REDIR, 5'b11111, 2, 0, 8);
      vecs[17] = mk(P_REDIR,    E_RUN,   5'b10001, 2, 1, 9);
      vecs[18] = mk(P_FRZ,      E_OFF,   5'b00011, 2, 1, 10);
      vecs[19] = mk(P_FRZ,      E_OFF,   5'b00011, 2, 1, 10);
      vecs[20] = mk(P_FRZ,      E_OFF,   5'b00011, 2, 1, 10);
      vecs[21] = mk(P_FRZ,      E_OFF,   5'b00011, 2, 1, 10);
      vecs[22] = mk(P_IDLE,     E_RUN,   5'b00011, 2, 1, 10);
      vecs[23] = mk(P_IDLE,     E_RUN,   5'b00111, 2, 1, 10);
      vecs[24] = mk(P_CLR,      E_RUN,   5'b01111, 2, 1, 10);
      vecs[25] = mk(P_IDLE,     E_RUN,   5'b11111, 0, 0, 0);

      repeat (2) @(negedge clk);
      #1;
      check("reset_ctl", 32'({pc_a, sen_a, fl_a, bub_a}), 32'(CTL_OFF));
      check("reset_valid", 32'(val_a), 32'd0);
      check("reset_counters", st_a | fc_a | rt_a, 32'd0);

      // Table: arst_n is released on the first vector, so vector 0 sees run=0.
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         arst_n = 1'b1;
         drive_pat(vecs[i].pat);
         exp_q.push_back({exp_ctl(vecs[i].ek), vecs[i].val, vecs[i].st, vecs[i].fc, vecs[i].rt});
         #1;
         e = exp_q.pop_front();
         check($sformatf("v%0d_ctl", i), 32'({pc_a, sen_a, fl_a, bub_a}), 32'(e[112:101]));
         check($sformatf("v%0d_valid", i), 32'(val_a), 32'(e[100:96]));
         check($sformatf("v%0d_stall_count", i), st_a, e[95:64]);
         check($sformatf("v%0d_flush_count", i), fc_a, e[63:32]);
         check($sformatf("v%0d_retired_count", i), rt_a, e[31:0]);
      end

      // Three-bubble instance: restart from reset and fill the pipe.
      @(negedge clk);
      drive_pat(P_IDLE);
      arst_n = 1'b0;
      #1;
      check("b_reset_ctl", 32'({pc_b, sen_b, fl_b, bub_b}), 32'(CTL_OFF));
      check("a_reset_retired", rt_a, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("b_filled_valid", 32'(val_b), 32'h1f);

      @(negedge clk);
      drive_pat(P_HZ1);
      #1;
      check("b_stall0_ctl", 32'({pc_b, sen_b, fl_b, bub_b}), 32'(CTL_STALL));
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         drive_pat(P_IDLE);
         #1;
         check($sformatf("b_stall%0d_valid2", i), 32'(val_b[2]), 32'd0);
         check($sformatf("b_stall%0d_ctl", i), 32'({pc_b, sen_b, fl_b, bub_b}),
               (i < 3) ? 32'(CTL_STALL) : 32'(CTL_RUN));
      end
      check("b_stall_count", 32'(st_b), 32'd3);

      repeat (25) @(negedge clk);
      #1;
      check("b_retired_saturated", 32'(rt_b), 32'd15);
      check("b_stall_count_kept", 32'(st_b), 32'd3);

      @(negedge clk);
      drive_pat(P_CLR);
      @(negedge clk);
      drive_pat(P_IDLE);
      #1;
      check("b_clear_stall", 32'(st_b), 32'd0);
      check("b_clear_flush", 32'(fc_b), 32'd0);
      check("b_clear_retired", 32'(rt_b), 32'd0);

      // Reset in the middle of a multi-cycle stall.
      @(negedge clk);
      drive_pat(P_HZ1);
      #1;
      check("b_midstall_ctl", 32'({pc_b, sen_b, fl_b, bub_b}), 32'(CTL_STALL));
      @(negedge clk);
      drive_pat(P_IDLE);
      arst_n = 1'b0;
      #1;
      check("b_abort_valid", 32'(val_b), 32'd0);
      check("b_abort_ctl", 32'({pc_b, sen_b, fl_b, bub_b}), 32'(CTL_OFF));
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      check("b_restart_wait_ctl", 32'({pc_b, sen_b, fl_b, bub_b}), 32'(CTL_OFF));
      @(negedge clk);
      #1;
      check("b_restart_no_stall", 32'({pc_b, sen_b, fl_b, bub_b}), 32'(CTL_RUN));

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised pipeline control unit for the in-order RISC-V core. It centralises the per-stage register enables that the core currently drives with free-running always-on regs. It tracks a valid bit per stage and detects load-use hazards, which it handles by stalling and inserting a bubble. It squashes younger stages on a taken branch/jump and keeps saturating performance counters. It sits beside the IF/ID/EX/MEM/WB registers and drives their enable and bubble inputs.

Parameters:
NUM_STAGES, 5, number of pipeline stages; index 0 = IF, 1 = ID, 2 = EX; minimum 3.
REG_ADDR_W, 5, register address width.
CNT_W, 32, width of each performance counter.
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; range 1..7.
FLUSH_STAGES, 3, stage index where branches and jumps resolve; range 1..NUM_STAGES-1.

Ports:
clk  in  1  clock
arst_n  in  1  reset, asynchronous, active-low
enable  in  1  run/freeze of the whole pipeline
rs1_id  in  REG_ADDR_W  rs1 of the instruction in ID
rs2_id  in  REG_ADDR_W  rs2 of the instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  REG_ADDR_W  rd of the instruction in EX
mem_read_ex  in  1  EX instruction is a load
redirect  in  1  instruction in stage FLUSH_STAGES is a taken branch or jump
clear_counters  in  1  synchronous clear of all counters
pc_write_en  out  1  PC update enable
stage_en  out  NUM_STAGES  load enable of the register entering each stage
flush  out  NUM_STAGES  load a bubble into the register entering stage i
bubble_id_ex  out  1  zero the control fields loaded into ID/EX
stage_valid  out  NUM_STAGES  the instruction in stage i is valid
stall_count  out  CNT_W  stall cycles
flush_count  out  CNT_W  redirect events
retired_count  out  CNT_W  valid instructions leaving the last stage

Behaviour:
- Reset (async): stage_valid=0, all counters=0, stall counter=0, run flag=0. While arst_n=0 or run=0, every output enable/flush/bubble is 0.
- The run flag sets on the first clk edge after reset release, giving a 1-cycle start-up latency.
- Define go = run & enable.
- If go=0: pc_write_en=0, stage_en=0, flush=0, bubble_id_ex=0. All state and counters hold.
- Normal (go, no hazard, no redirect):
  - pc_write_en=1 and stage_en all 1.
  - valid[0]<=1, and valid[i]<=valid[i-1] for i≥1.
- Load-use hazard: hz = valid[1] & valid[2] & mem_read_ex & rd_ex≠0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- Stall condition: stall = go & ~redirect_v & (hz | scnt≠0).
- During stall:
  - pc_write_en=0 and stage_en[1:0]=0, so IF and ID hold; stage_en[others]=1.
  - bubble_id_ex=1 and flush[2]=1, so valid[2]<=0; later stages advance normally.
  - Stall counter scnt: on hz with scnt=0, scnt<=LOAD_STALL_CYCLES-1; while scnt≠0, scnt decrements.
- Redirect: redirect_v = go & redirect & valid[FLUSH_STAGES]. If valid[FLUSH_STAGES]=0, redirect is ignored.
  - flush[i]=1 for 1≤i≤FLUSH_STAGES, so valid[i]<=0 for those stages; stage_en all 1.
  - pc_write_en=1 (PC loads the target), and valid[0]<=1.
  - Redirect has priority over stall: a simultaneous hazard is not stalled, and scnt<=0.
  - bubble_id_ex=1 whenever flush[2]=1.
- Counters:
  - stall_count +1 per stall cycle.
  - flush_count +1 per redirect_v.
  - retired_count +1 when go & valid[NUM_STAGES-1].
  - All counters saturate at all-ones.
  - clear_counters has priority over increment and takes effect next cycle.
- Reset mid-stall or mid-flush aborts immediately: all state returns to reset values.

Test Plan:
- Startup: release arst_n with enable=1 → run=1 after 1 edge; stage_valid goes 00001, 00011, …, 11111 on successive cycles; retired_count reaches 1 one cycle after stage_valid[4]=1.
- Load-use with valid[1] and valid[2] set, mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 → one cycle of pc_write_en=0, stage_en=11100, bubble_id_ex=1; stall_count 0→1; next cycle normal. Same stimulus with rd_ex=0, or with rs1_used_id=0, → no stall.
- LOAD_STALL_CYCLES=3 instance with the same hazard → 3 consecutive stall cycles; stall_count=3; valid[2]=0 for 3 cycles.
- Redirect with valid[3]=1 asserted together with a hazard → flush=01110, pc_write_en=1, bubble_id_ex=1; next cycle stage_valid[3:1]=000; flush_count=1; stall_count unchanged. Redirect with valid[3]=0 → no effect.
- Freeze: enable=0 for 4 cycles mid-run → stage_en=0, pc_write_en=0, counters and stage_valid frozen; enable=1 resumes from the same state.
- Saturation with a CNT_W=4 instance: 20 retiring cycles → retired_count=15; pulse clear_counters → all counters 0 next cycle; assert arst_n=0 mid-stall → scnt=0 and stage_valid=0 immediately.
